// File: rtl/flash_addr_pkg.sv
// Shared types and constants for the flash sample-address sequencer.
// Optional feature macro used by the design: FLASH_ADDR_WRAP_EN.
package flash_addr_pkg;

    localparam int ADDR_W   = 23;
    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;

    localparam logic [ADDR_W-1:0] ADDR_MAX_DEF = 23'h7FFFF;
    localparam logic [ADDR_W-1:0] ADDR_MIN_DEF = 23'h000000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        REQ       = 3'd2,
        WAIT_FIN  = 3'd3,
        EMIT      = 3'd4
    } state_t;

    // Pick one 16-bit sample out of a fetched word. Forward playback takes
    // the low half first; backward playback takes the high half first.
    function automatic logic [SAMPLE_W-1:0] pick_half(
        input logic [WORD_W-1:0] word,
        input logic              forward,
        input logic              second
    );
        return (forward ^ second) ? word[15:0] : word[31:16];
    endfunction

endpackage

// File: rtl/flash_addr_sequencer_addr_step.sv
// Combinational next-address generator for the sample region.
// With FLASH_ADDR_WRAP_EN defined the address wraps at the region edges;
// otherwise it holds at the edge and the boundary flag tells the FSM to stop.
module addr_step
    import flash_addr_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_MAX_DEF,
    parameter logic [ADDR_W-1:0] ADDR_MIN = ADDR_MIN_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              forward,
    output logic [ADDR_W-1:0] next_addr,
    output logic              at_boundary
);

    // Step one word in the playback direction and flag the region edge.
    always_comb begin
        at_boundary = forward ? (addr == ADDR_MAX) : (addr == ADDR_MIN);
        next_addr   = forward ? (addr + ADDR_W'(1)) : (addr - ADDR_W'(1));
        if (at_boundary) begin
`ifdef FLASH_ADDR_WRAP_EN
            next_addr = forward ? ADDR_MIN : ADDR_MAX;
`else
            next_addr = addr;
`endif
        end
    end

endmodule

// File: rtl/flash_addr_sequencer.sv
// Flash sample-address sequencer: fetches 32-bit words from a flash reader
// and plays them back as two 16-bit samples, one per sample tick.
// Optional feature macro: FLASH_ADDR_WRAP_EN (wrap at region boundaries
// instead of stopping).
module flash_addr_sequencer
    import flash_addr_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_MAX_DEF,
    parameter logic [ADDR_W-1:0] ADDR_MIN = ADDR_MIN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic                play,
    input  logic                direction,
    input  logic                restart,
    output logic [ADDR_W-1:0]   address_to_reader,
    output logic                start,
    input  logic                finish,
    input  logic [WORD_W-1:0]   word_data,
    output logic [SAMPLE_W-1:0] audio_sample,
    output logic                audio_valid,
    output logic                overrun,
    output logic                end_reached
);

`ifdef FLASH_ADDR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    state_t                state_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic                  start_reg;
    logic [SAMPLE_W-1:0]   sample_reg;
    logic                  valid_reg;
    logic                  overrun_reg;
    logic                  end_reg;
    logic                  restart_pend_reg;
    logic                  half_pend_reg;
    logic [WORD_W-1:0]     word_reg;
    logic                  fwd_reg;
    logic                  halted_reg;

    logic [ADDR_W-1:0]     step_addr;
    logic                  at_boundary;
    logic                  restart_any;
    logic [ADDR_W-1:0]     restart_addr;
    logic                  halt_now;

    addr_step #(
        .ADDR_MAX (ADDR_MAX),
        .ADDR_MIN (ADDR_MIN)
    ) u_addr_step (
        .addr        (addr_reg),
        .forward     (fwd_reg),
        .next_addr   (step_addr),
        .at_boundary (at_boundary)
    );

    // A restart seen this cycle counts as pending so it can beat a same-cycle tick.
    assign restart_any  = restart | restart_pend_reg;
    assign restart_addr = direction ? ADDR_MIN : ADDR_MAX;
    // Without wrapping, finishing the last word of the region parks the FSM.
    assign halt_now     = !WRAP_EN && half_pend_reg && at_boundary;

    // Playback FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            addr_reg         <= ADDR_MIN;
            start_reg        <= 1'b0;
            sample_reg       <= '0;
            valid_reg        <= 1'b0;
            overrun_reg      <= 1'b0;
            end_reg          <= 1'b0;
            restart_pend_reg <= 1'b0;
            half_pend_reg    <= 1'b0;
            word_reg         <= '0;
            fwd_reg          <= 1'b1;
            halted_reg       <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            end_reg   <= 1'b0;
            if (restart) begin
                restart_pend_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (restart_any) begin
                        addr_reg         <= restart_addr;
                        half_pend_reg    <= 1'b0;
                        restart_pend_reg <= 1'b0;
                        halted_reg       <= 1'b0;
                    end else if (play && !halted_reg) begin
                        state_reg <= WAIT_TICK;
                    end
                end

                WAIT_TICK: begin
                    if (restart_any) begin
                        // Restart wins over a coincident tick; the tick is simply dropped.
                        addr_reg         <= restart_addr;
                        half_pend_reg    <= 1'b0;
                        restart_pend_reg <= 1'b0;
                        if (!play) begin
                            state_reg <= IDLE;
                        end
                    end else if (!play) begin
                        state_reg <= IDLE;
                    end else if (sample_tick) begin
                        if (half_pend_reg) begin
                            // Second half is already in hand; no flash access needed.
                            state_reg  <= EMIT;
                            valid_reg  <= 1'b1;
                            sample_reg <= pick_half(word_reg, fwd_reg, 1'b1);
                        end else begin
                            state_reg <= REQ;
                            start_reg <= 1'b1;
                            fwd_reg   <= direction;
                        end
                    end
                end

                REQ, WAIT_FIN: begin
                    if (sample_tick) begin
                        overrun_reg <= 1'b1;
                    end
                    if (finish) begin
                        start_reg <= 1'b0;
                        word_reg  <= word_data;
                        if (restart_any) begin
                            // Fetched data is discarded; jump straight to the region start.
                            addr_reg         <= restart_addr;
                            half_pend_reg    <= 1'b0;
                            restart_pend_reg <= 1'b0;
                            state_reg        <= play ? WAIT_TICK : IDLE;
                        end else begin
                            state_reg  <= EMIT;
                            valid_reg  <= 1'b1;
                            sample_reg <= pick_half(word_data, fwd_reg, 1'b0);
                        end
                    end else if (state_reg == REQ) begin
                        state_reg <= WAIT_FIN;
                    end
                end

                EMIT: begin
                    if (sample_tick) begin
                        overrun_reg <= 1'b1;
                    end
                    if (half_pend_reg) begin
                        half_pend_reg <= 1'b0;
                        addr_reg      <= step_addr;
                        if (at_boundary) begin
                            end_reg <= 1'b1;
                        end
                        if (halt_now) begin
                            halted_reg <= 1'b1;
                        end
                    end else begin
                        half_pend_reg <= 1'b1;
                    end
                    state_reg <= (halt_now || !play) ? IDLE : WAIT_TICK;
                end

                default: begin
                    state_reg <= IDLE;
                    start_reg <= 1'b0;
                end
            endcase
        end
    end

    assign address_to_reader = addr_reg;
    assign start             = start_reg;
    assign audio_sample      = sample_reg;
    assign audio_valid       = valid_reg;
    assign overrun           = overrun_reg;
    assign end_reached       = end_reg;

endmodule

// File: tb/tb_flash_addr_sequencer.sv
// Bench for flash_addr_sequencer: table of word fetches plus hand-written
// corner sequences; expected samples queue up as ticks are driven and are
// compared whenever audio_valid strobes. Honours FLASH_ADDR_WRAP_EN.
module tb_flash_addr_sequencer;

    typedef struct {
        logic        dir;
        logic [22:0] fetch_addr;
        logic [31:0] word;
        logic [15:0] s0;
        logic [15:0] s1;
        logic [22:0] addr_after;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic        play = 1'b0;
    logic        direction = 1'b1;
    logic        restart = 1'b0;
    logic        finish = 1'b0;
    logic [31:0] word_data = 32'h0;
    logic [22:0] address_to_reader;
    logic        start;
    logic [15:0] audio_sample;
    logic        audio_valid;
    logic        overrun;
    logic        end_reached;

    int          total = 0;
    int          bad = 0;
    int          n_valid = 0;
    logic [15:0] exp_q[$];
    logic        prev_valid = 1'b0;
    vec_t        vecs[11];

    flash_addr_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .sample_tick       (sample_tick),
        .play              (play),
        .direction         (direction),
        .restart           (restart),
        .address_to_reader (address_to_reader),
        .start             (start),
        .finish            (finish),
        .word_data         (word_data),
        .audio_sample      (audio_sample),
        .audio_valid       (audio_valid),
        .overrun           (overrun),
        .end_reached       (end_reached)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && audio_valid) begin
            n_valid++;
            check("valid_one_cycle", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: actual sample=%h required=no strobe", audio_sample);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("audio_sample", 32'(audio_sample), 32'(e));
            end
        end
        prev_valid = audio_valid;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int i;
        i = 0;
        while (start !== 1'b1 && i < 20) begin
            cyc();
            i++;
        end
        check(name, 32'(start), 32'd1);
    endtask

    task automatic fetch_word(input string name, input logic [22:0] exp_addr,
                              input logic [31:0] w, input int lat);
        issue_tick();
        wait_start({name, "_start"});
        check({name, "_addr"}, 32'(address_to_reader), 32'(exp_addr));
        repeat (lat) cyc();
        check({name, "_held"}, 32'({start, address_to_reader}), 32'({1'b1, exp_addr}));
        finish = 1'b1;
        word_data = w;
        cyc();
        finish = 1'b0;
        word_data = $urandom;
        check({name, "_start_drop"}, 32'(start), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nv;
        bit ok;

        vecs[0]  = '{1'b1, 23'd0, 32'hBEEF_1234, 16'h1234, 16'hBEEF, 23'd1};
        vecs[1]  = '{1'b1, 23'd1, 32'h0102_0304, 16'h0304, 16'h0102, 23'd2};
        vecs[2]  = '{1'b1, 23'd2, 32'hFFFF_8000, 16'h8000, 16'hFFFF, 23'd3};
        vecs[3]  = '{1'b1, 23'd3, 32'h1357_2468, 16'h2468, 16'h1357, 23'd4};
        vecs[4]  = '{1'b1, 23'd4, 32'hDEAD_C0DE, 16'hC0DE, 16'hDEAD, 23'd5};
        vecs[5]  = '{1'b0, 23'd5, 32'hAAAA_5555, 16'hAAAA, 16'h5555, 23'd4};
        vecs[6]  = '{1'b1, 23'd4, 32'h0000_7FFF, 16'h7FFF, 16'h0000, 23'd5};
        vecs[7]  = '{1'b1, 23'd5, 32'hCAFE_0001, 16'h0001, 16'hCAFE, 23'd6};
        vecs[8]  = '{1'b1, 23'd6, 32'h0F0F_F0F0, 16'hF0F0, 16'h0F0F, 23'd7};
        vecs[9]  = '{1'b1, 23'd7, 32'h8001_7FFE, 16'h7FFE, 16'h8001, 23'd8};
        vecs[10] = '{1'b1, 23'd8, 32'h5A5A_A5A5, 16'hA5A5, 16'h5A5A, 23'd9};

        // Reset state.
        rst = 1'b1;
        repeat (3) cyc();
        check("rst_addr", 32'(address_to_reader), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_sample", 32'(audio_sample), 32'd0);
        check("rst_valid", 32'(audio_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_end", 32'(end_reached), 32'd0);
        rst = 1'b0;
        play = 1'b1;
        direction = 1'b1;
        cyc();
        cyc();

        // Table of fetches; direction flips after each fetch to show it is sampled at fetch.
        for (int i = 0; i < 11; i++) begin
            nv = n_valid;
            direction = vecs[i].dir;
            exp_q.push_back(vecs[i].s0);
            fetch_word($sformatf("vec%0d", i), vecs[i].fetch_addr, vecs[i].word, i % 4);
            cyc();
            direction = !vecs[i].dir;
            exp_q.push_back(vecs[i].s1);
            issue_tick();
            cyc();
            check($sformatf("vec%0d_addr_after", i), 32'(address_to_reader), 32'(vecs[i].addr_after));
            check($sformatf("vec%0d_valid_count", i), 32'(n_valid - nv), 32'd2);
        end
        direction = 1'b1;

        // Restart during an outstanding fetch at address 9: data discarded.
        nv = n_valid;
        issue_tick();
        wait_start("rs_start");
        check("rs_fetch_addr", 32'(address_to_reader), 32'd9);
        cyc();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        cyc();
        finish = 1'b1;
        word_data = 32'h1357_9BDF;
        cyc();
        finish = 1'b0;
        cyc();
        cyc();
        check("rs_addr", 32'(address_to_reader), 32'd0);
        check("rs_no_valid", 32'(n_valid - nv), 32'd0);

        // Next tick fetches 0; a tick while waiting sets overrun and is dropped.
        nv = n_valid;
        exp_q.push_back(16'h4444);
        issue_tick();
        wait_start("ov_start");
        check("ov_fetch_addr", 32'(address_to_reader), 32'd0);
        cyc();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        cyc();
        check("ov_overrun", 32'(overrun), 32'd1);
        finish = 1'b1;
        word_data = 32'h3333_4444;
        cyc();
        finish = 1'b0;
        cyc();
        cyc();
        check("ov_one_valid", 32'(n_valid - nv), 32'd1);
        exp_q.push_back(16'h3333);
        issue_tick();
        cyc();
        check("ov_addr_after", 32'(address_to_reader), 32'd1);
        check("ov_sticky", 32'(overrun), 32'd1);

        // Boundary: backward restart lands on ADDR_MAX, then play forward past it.
        direction = 1'b0;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        cyc();
        check("bnd_restart_addr", 32'(address_to_reader), 32'h7FFFF);
        direction = 1'b1;
        exp_q.push_back(16'h2222);
        fetch_word("bnd", 23'h7FFFF, 32'h1111_2222, 1);
        cyc();
        exp_q.push_back(16'h1111);
        issue_tick();
        cyc();
        check("bnd_end_pulse", 32'(end_reached), 32'd1);
`ifdef FLASH_ADDR_WRAP_EN
        check("bnd_addr", 32'(address_to_reader), 32'd0);
`else
        check("bnd_addr", 32'(address_to_reader), 32'h7FFFF);
`endif
        cyc();
        check("bnd_end_clear", 32'(end_reached), 32'd0);
`ifndef FLASH_ADDR_WRAP_EN
        issue_tick();
        ok = 1'b1;
        repeat (5) begin
            if (start !== 1'b0) ok = 1'b0;
            cyc();
        end
        check("bnd_halt_ignores_play", 32'(ok), 32'd1);
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        cyc();
        check("bnd_restart_after_halt", 32'(address_to_reader), 32'd0);
`endif

        // Playback resumes at 0 in either build.
        exp_q.push_back(16'hABCD);
        fetch_word("resume", 23'd0, 32'h5678_ABCD, 2);
        cyc();
        exp_q.push_back(16'h5678);
        issue_tick();
        cyc();
        check("resume_addr", 32'(address_to_reader), 32'd1);

        // Reset in the middle of a fetch; a late finish must be ignored.
        issue_tick();
        wait_start("mrst_start");
        #2;
        rst = 1'b1;
        #1;
        check("mrst_start_low", 32'(start), 32'd0);
        check("mrst_addr", 32'(address_to_reader), 32'd0);
        check("mrst_overrun", 32'(overrun), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        nv = n_valid;
        finish = 1'b1;
        word_data = 32'h9999_7777;
        cyc();
        finish = 1'b0;
        cyc();
        cyc();
        check("mrst_stray_finish", 32'(n_valid - nv), 32'd0);
        check("mrst_no_start", 32'(start), 32'd0);

        // Restart coincident with a tick: restart wins, no fetch, no overrun.
        direction = 1'b0;
        sample_tick = 1'b1;
        restart = 1'b1;
        cyc();
        sample_tick = 1'b0;
        restart = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            if (start !== 1'b0) ok = 1'b0;
            cyc();
        end
        check("coinc_no_fetch", 32'(ok), 32'd1);
        check("coinc_overrun", 32'(overrun), 32'd0);
        check("coinc_addr", 32'(address_to_reader), 32'h7FFFF);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
